// File: rtl/main_memory_responder.sv
// Line-granular memory serving I$/D$ misses one at a time with round-robin arbitration.
// Latency: MEM_LATENCY cycles from grant to a one-cycle response. Requests hold valid until served, with no other backpressure.
`ifndef DCACHE_LINE_WIDTH
`define DCACHE_LINE_WIDTH 512
`endif

package memory_pkg;
  typedef struct packed {
    logic [31:0]                   addr;
    logic                          is_store;
    logic [`DCACHE_LINE_WIDTH-1:0] data;
  } memory_request_t;
endpackage

module main_memory_responder
  import memory_pkg::*;
#(
  parameter int MEM_LATENCY     = 10,
  parameter int MEM_DEPTH_LINES = 4096,
  parameter int LINE_WIDTH      = `DCACHE_LINE_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  dcache_req_valid_miss,
  input  memory_request_t       dcache_req_info_miss,
  input  logic                  icache_req_valid_miss,
  input  memory_request_t       icache_req_info_miss,
  output logic [LINE_WIDTH-1:0] rsp_data_miss,
  output logic                  rsp_valid_miss,
  output logic                  rsp_cache_id
);

  localparam int OFF_W = $clog2(LINE_WIDTH / 8);
  localparam int IDX_W = $clog2(MEM_DEPTH_LINES);
  localparam int CNT_W = $clog2(MEM_LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  memory_request_t req_q, req_sel;
  logic            id_q;
  logic            last_grant_q;  // 1 = D$ was granted last
  logic            grant;
  logic            grant_dc;
  logic            resp_fire;
  logic [IDX_W-1:0] line_idx;
  logic            unused_addr;

  logic [LINE_WIDTH-1:0] mem [MEM_DEPTH_LINES];

  // Upper address bits fall outside the array, so accesses wrap modulo depth.
  assign line_idx    = req_q.addr[OFF_W +: IDX_W];
  assign unused_addr = ^req_q.addr;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant     = 1'b0;
    resp_fire = 1'b0;
    grant_dc  = dcache_req_valid_miss && (!icache_req_valid_miss || !last_grant_q);
    req_sel   = icache_req_info_miss;
    req_sel.is_store = 1'b0;
    if (grant_dc) begin
      req_sel = dcache_req_info_miss;
    end

    case (state_q)
      IDLE: begin
        if (dcache_req_valid_miss || icache_req_valid_miss) begin
          grant   = 1'b1;
          cnt_d   = CNT_W'(MEM_LATENCY - 2);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          resp_fire = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      req_q          <= '0;
      id_q           <= 1'b0;
      last_grant_q   <= 1'b0;
      rsp_valid_miss <= 1'b0;
      rsp_data_miss  <= '0;
      rsp_cache_id   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rsp_valid_miss <= resp_fire;
      if (grant) begin
        req_q        <= req_sel;
        id_q         <= grant_dc;
        last_grant_q <= grant_dc;
      end
      // Response registers load on the edge into RESP; a store echoes its own data.
      if (resp_fire) begin
        rsp_cache_id  <= id_q;
        rsp_data_miss <= req_q.is_store ? req_q.data : mem[line_idx];
      end
    end
  end

  // Array has no reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clock) begin
    if (!reset && resp_fire && req_q.is_store) begin
      mem[line_idx] <= req_q.data;
    end
  end

endmodule
